// File: rtl/serial_sub_16_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_16_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

  localparam int SUB_WIDTH = 16;
  localparam int SUB_CNT_W = $clog2(SUB_WIDTH);

endpackage

// File: rtl/serial_sub_16_full_adder_1b.sv
// One-bit full adder: the whole arithmetic datapath of the serial subtractor.
module full_adder_1b (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_sub_16.sv
// Bit-serial subtractor computing a - b LSB first, one bit per clock.
// Optional signed-overflow flag port ovf is built when SUB_OVF_EN is defined.
module serial_sub_16
  import serial_sub_16_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH == SUB_WIDTH) ? SUB_CNT_W : $clog2(WIDTH);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             sum_bit;
  logic             carry_next;
  logic             b_inv;

`ifdef SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // Subtraction as a + ~b + 1: the +1 comes from presetting carry on start.
  assign b_inv = ~b_sr[0];

  full_adder_1b u_fa (
    .x    (a_sr[0]),
    .y    (b_inv),
    .cin  (carry),
    .s    (sum_bit),
    .cout (carry_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      cnt        <= '0;
      carry      <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
`ifdef SUB_OVF_EN
      ovf        <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b1;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
`ifdef SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Result fills from the MSB side so bit 0 lands in place after WIDTH shifts.
          diff  <= {sum_bit, diff[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= carry_next;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            borrow_out <= ~carry_next;
`ifdef SUB_OVF_EN
            ovf        <= (a_msb != b_msb) && (sum_bit != a_msb);
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
